// File: rtl/pkt_pkg.sv
// ----------------------------------------------------------------------------
// pkt_pkg
// Purpose : Constants shared by the packet transmit builder and the receive
//           side: packet type codes, packet lengths in bytes (type and
//           checksum bytes included), byte index width and the builder FSM
//           state encoding.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package pkt_pkg;

   localparam logic [7:0] PKT_HB   = 8'h01;
   localparam logic [7:0] PKT_QADV = 8'h02;

   localparam int unsigned HB_LEN   = 6;
   localparam int unsigned QADV_LEN = 14;

   localparam int unsigned BYTE_IDX_W = 4;
   localparam int unsigned NUM_FIELDS = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      CSUM = 2'd2,
      DONE = 2'd3
   } pktState_t;

   // True for the packet codes the builder knows how to send.
   function automatic logic isValidType(input logic [7:0] code);
      return (code == PKT_HB) || (code == PKT_QADV);
   endfunction

endpackage

// File: rtl/pkt_tx_builder.sv
// ----------------------------------------------------------------------------
// pkt_tx_builder
// Purpose : On a start request, latches this node's fields and streams a
//           packet out one byte at a time under a valid/ready handshake:
//           type byte, fields MSB-first, then an XOR checksum byte.
//           HB carries nodeID and hops; QADV carries all six fields.
// Ports   :
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle build request (ignored while busy)
//   pktType           packet code, sampled with start
//   my*               node fields (WORD_WIDTH each), sampled with start
//   txReady           downstream accepts txData this cycle
//   txData / txValid  outgoing byte and its qualifier
//   txLast            marks the checksum byte
//   busy              packet in progress (SEND, CSUM, DONE)
//   done              one-cycle pulse after the checksum byte is accepted
//   err               one-cycle pulse for start with an invalid pktType
// Outputs are decoded from registered state only, so they are glitch-free
// with respect to the inputs and hold steady while txReady is low.
// ----------------------------------------------------------------------------
module pkt_tx_builder
   import pkt_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = 16,
   parameter int unsigned MEM_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [7:0]            pktType,
   input  logic [WORD_WIDTH-1:0] myNodeID,
   input  logic [WORD_WIDTH-1:0] myHops,
   input  logic [WORD_WIDTH-1:0] myQValue,
   input  logic [WORD_WIDTH-1:0] myEnergy,
   input  logic [WORD_WIDTH-1:0] myHopsFromCH,
   input  logic [WORD_WIDTH-1:0] myChosenCH,
   input  logic                  txReady,
   output logic [MEM_WIDTH-1:0]  txData,
   output logic                  txValid,
   output logic                  txLast,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int unsigned BYTES_PER_FIELD = WORD_WIDTH / MEM_WIDTH;
   localparam int unsigned FIELD_VEC_W     = NUM_FIELDS * WORD_WIDTH;
   localparam int unsigned MAX_FIELD_BYTES = NUM_FIELDS * BYTES_PER_FIELD;

   pktState_t state;
   pktState_t stateNext;

   logic [7:0]            typeQ;
   logic [WORD_WIDTH-1:0] nodeIdQ;
   logic [WORD_WIDTH-1:0] hopsQ;
   logic [WORD_WIDTH-1:0] qValueQ;
   logic [WORD_WIDTH-1:0] energyQ;
   logic [WORD_WIDTH-1:0] hopsFromChQ;
   logic [WORD_WIDTH-1:0] chosenChQ;

   logic [BYTE_IDX_W-1:0] byteIdx;
   logic [MEM_WIDTH-1:0]  csumQ;
   logic                  errQ;

   logic                  loadEn;
   logic                  errNext;
   logic                  xfer;
   logic [BYTE_IDX_W-1:0] lastFieldIdx;
   logic [FIELD_VEC_W-1:0] fieldVec;
   logic [MEM_WIDTH-1:0]  fieldByte;

   // Fields in transmit order; an HB packet simply stops after the first two.
   assign fieldVec = {nodeIdQ, hopsQ, qValueQ, energyQ, hopsFromChQ, chosenChQ};

   // Index of the final field byte: packet length minus type and checksum.
   assign lastFieldIdx = (typeQ == PKT_HB) ? BYTE_IDX_W'(HB_LEN - 2)
                                           : BYTE_IDX_W'(QADV_LEN - 2);

   assign xfer = txValid && txReady;

   // Next-state logic.
   always_comb begin
      stateNext = state;
      loadEn    = 1'b0;
      errNext   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (isValidType(pktType)) begin
                  loadEn    = 1'b1;
                  stateNext = SEND;
               end else begin
                  errNext = 1'b1;
               end
            end
         end
         SEND: begin
            if (txReady && (byteIdx == lastFieldIdx)) begin
               stateNext = CSUM;
            end
         end
         CSUM: begin
            if (txReady) begin
               stateNext = DONE;
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Byte mux: index 0 is the type byte, index k>0 is field byte k-1.
   always_comb begin
      fieldByte = '0;
      if (byteIdx == '0) begin
         fieldByte = MEM_WIDTH'(typeQ);
      end
      for (int i = 0; i < int'(MAX_FIELD_BYTES); i++) begin
         if (byteIdx == BYTE_IDX_W'(i + 1)) begin
            fieldByte = fieldVec[FIELD_VEC_W - 1 - i * MEM_WIDTH -: MEM_WIDTH];
         end
      end
   end

   // Output decode from registered state.
   always_comb begin
      txValid = 1'b0;
      txLast  = 1'b0;
      txData  = '0;
      busy    = (state != IDLE);
      done    = (state == DONE);
      err     = errQ;
      case (state)
         SEND: begin
            txValid = 1'b1;
            txData  = fieldByte;
         end
         CSUM: begin
            txValid = 1'b1;
            txLast  = 1'b1;
            txData  = csumQ;
         end
         default: begin
            txValid = 1'b0;
         end
      endcase
   end

   // State, latched fields, byte index and running checksum.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         errQ        <= 1'b0;
         typeQ       <= '0;
         nodeIdQ     <= '0;
         hopsQ       <= '0;
         qValueQ     <= '0;
         energyQ     <= '0;
         hopsFromChQ <= '0;
         chosenChQ   <= '0;
         byteIdx     <= '0;
         csumQ       <= '0;
      end else begin
         state <= stateNext;
         errQ  <= errNext;
         if (loadEn) begin
            typeQ       <= pktType;
            nodeIdQ     <= myNodeID;
            hopsQ       <= myHops;
            qValueQ     <= myQValue;
            energyQ     <= myEnergy;
            hopsFromChQ <= myHopsFromCH;
            chosenChQ   <= myChosenCH;
            byteIdx     <= '0;
            csumQ       <= '0;
         end else if (xfer) begin
            // Longest packet ends at index 13, so the 4-bit index never wraps.
            byteIdx <= byteIdx + BYTE_IDX_W'(1);
            csumQ   <= csumQ ^ txData;
         end
      end
   end

endmodule

// File: tb/tb_pkt_tx_builder.sv
// ----------------------------------------------------------------------------
// tb_pkt_tx_builder
// Purpose : Self-checking bench for pkt_tx_builder. A packet-level model
//           builds the expected byte list for each accepted start; a monitor
//           checks every presented byte, txLast and the done pulse against
//           it. Directed sequences also compare received bytes against
//           hand-computed literal packets.
// ----------------------------------------------------------------------------
module tb_pkt_tx_builder;
   import pkt_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  pktType;
   logic [15:0] myNodeID, myHops, myQValue, myEnergy, myHopsFromCH, myChosenCH;
   logic        txReady;
   logic [7:0]  txData;
   logic        txValid, txLast, busy, done, err;

   int errors = 0;
   int checks = 0;

   logic [7:0] expQ[$];
   logic       doneDue = 1'b0;
   logic [7:0] rec[$];
   logic [7:0] held[$];
   int         doneCyc;

   logic [7:0] hbLit[6]    = '{8'h01, 8'h00, 8'h19, 8'h00, 8'h02, 8'h1A};
   logic [7:0] qadvLit[14] = '{8'h02, 8'h00, 8'h19, 8'h00, 8'h02, 8'h40, 8'h00,
                               8'h33, 8'h33, 8'h00, 8'h02, 8'h00, 8'h19, 8'h42};

   always #5 clk = ~clk;

   pkt_tx_builder #(.WORD_WIDTH(16), .MEM_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .pktType(pktType),
      .myNodeID(myNodeID), .myHops(myHops), .myQValue(myQValue),
      .myEnergy(myEnergy), .myHopsFromCH(myHopsFromCH), .myChosenCH(myChosenCH),
      .txReady(txReady), .txData(txData), .txValid(txValid), .txLast(txLast),
      .busy(busy), .done(done), .err(err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Packet model: type, words MSB-first, XOR of everything before it.
   task automatic modelPkt(input logic [7:0] t,
                           input logic [15:0] a, b, c, d, e, f);
      logic [15:0] w[6];
      logic [7:0]  bytes[$];
      logic [7:0]  x;
      int          n;
      w = '{a, b, c, d, e, f};
      n = (t == PKT_HB) ? 2 : 6;
      bytes.push_back(t);
      for (int i = 0; i < n; i++) begin
         bytes.push_back(w[i][15:8]);
         bytes.push_back(w[i][7:0]);
      end
      x = 8'h00;
      foreach (bytes[i]) x = x ^ bytes[i];
      bytes.push_back(x);
      foreach (bytes[i]) expQ.push_back(bytes[i]);
   endtask

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (rst) begin
         expQ.delete();
         doneDue = 1'b0;
      end else begin
         chk("done", 32'(done), 32'(doneDue));
         doneDue = 1'b0;
         if (txValid) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpectedValid: txValid=1 txData=%0h, required no byte", txData);
            end else begin
               chk("txData", 32'(txData), 32'(expQ[0]));
               chk("txLast", 32'(txLast), 32'(expQ.size() == 1));
               chk("busyWhileValid", 32'(busy), 32'd1);
               if (txReady) begin
                  void'(expQ.pop_front());
                  if (expQ.size() == 0) doneDue = 1'b1;
               end
            end
         end
      end
   end

   task automatic setFields(input logic [15:0] a, b, c, d, e, f);
      myNodeID = a; myHops = b; myQValue = c;
      myEnergy = d; myHopsFromCH = e; myChosenCH = f;
   endtask

   // Start a packet and run it to done, recording accepted and stalled bytes.
   task automatic sendPkt(input logic [7:0] t, input logic [15:0] a, b, c, d, e, f,
                          input int stallStart, input int stallLen,
                          input bit midDisturb, input int len);
      rec.delete();
      held.delete();
      doneCyc = 0;
      modelPkt(t, a, b, c, d, e, f);
      pktType = t;
      setFields(a, b, c, d, e, f);
      start   = 1'b1;
      txReady = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 1; cyc <= 60 && doneCyc == 0; cyc++) begin
         txReady = !(cyc >= stallStart && cyc < stallStart + stallLen);
         if (midDisturb && cyc == 3) begin
            start   = 1'b1;
            pktType = PKT_HB;
            setFields(16'hFFFF, 16'hEEEE, 16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA);
         end
         if (midDisturb && cyc == 4) start = 1'b0;
         @(negedge clk);
         if (cyc == 1) chk("latencyTxValid", 32'(txValid), 32'd1);
         if (txValid && !txReady) held.push_back(txData);
         if (txValid && txReady) rec.push_back(txData);
         if (done) doneCyc = cyc;
         @(posedge clk); #1;
      end
      start   = 1'b0;
      txReady = 1'b1;
      chk("doneCycle", 32'(doneCyc), 32'(len + stallLen + 1));
   endtask

   task automatic cmpHb(input string nm);
      chk({nm, "Len"}, 32'(rec.size()), 32'd6);
      for (int i = 0; i < 6; i++) chk(nm, 32'(rec[i]), 32'(hbLit[i]));
   endtask

   task automatic cmpQadv(input string nm);
      chk({nm, "Len"}, 32'(rec.size()), 32'd14);
      for (int i = 0; i < 14; i++) chk(nm, 32'(rec[i]), 32'(qadvLit[i]));
   endtask

   task automatic chkAllZero(input string nm);
      chk({nm, "TxData"},  32'(txData),  32'd0);
      chk({nm, "TxValid"}, 32'(txValid), 32'd0);
      chk({nm, "TxLast"},  32'(txLast),  32'd0);
      chk({nm, "Busy"},    32'(busy),    32'd0);
      chk({nm, "Done"},    32'(done),    32'd0);
      chk({nm, "Err"},     32'(err),     32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; txReady = 1'b1; pktType = 8'h00;
      setFields(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      repeat (2) @(posedge clk);
      #1;
      chkAllZero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Heartbeat with txReady always high.
      sendPkt(PKT_HB, 16'd25, 16'd2, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 1'b0, 6);
      cmpHb("hbByte");

      // Q-advertisement.
      sendPkt(PKT_QADV, 16'd25, 16'd2, 16'h4000, 16'h3333, 16'd2, 16'd25, 0, 0, 1'b0, 14);
      cmpQadv("qadvByte");

      // Same QADV stalled for 3 cycles while byte 5 is presented.
      sendPkt(PKT_QADV, 16'd25, 16'd2, 16'h4000, 16'h3333, 16'd2, 16'd25, 6, 3, 1'b0, 14);
      cmpQadv("stallByte");
      chk("stallHeldCount", 32'(held.size()), 32'd3);
      foreach (held[i]) chk("stallHeldByte", 32'(held[i]), 32'h40);

      // Invalid packet code.
      pktType = 8'h07; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("invalidErr", 32'(err), 32'd1);
      chk("invalidTxValid", 32'(txValid), 32'd0);
      chk("invalidBusy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("invalidErrPulse", 32'(err), 32'd0);
      chk("invalidBusyAfter", 32'(busy), 32'd0);
      chk("invalidTxValidAfter", 32'(txValid), 32'd0);

      // Start and field changes while a QADV is in flight.
      sendPkt(PKT_QADV, 16'd25, 16'd2, 16'h4000, 16'h3333, 16'd2, 16'd25, 0, 0, 1'b1, 14);
      cmpQadv("disturbByte");
      chk("disturbNoErr", 32'(err), 32'd0);

      // Reset wins over start in the same cycle.
      rst = 1'b1; start = 1'b1; pktType = PKT_HB;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      chk("rstPriorityBusy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("rstPriorityBusyLater", 32'(busy), 32'd0);
      chk("rstPriorityTxValid", 32'(txValid), 32'd0);

      // Reset after four bytes of a QADV, then a fresh heartbeat.
      modelPkt(PKT_QADV, 16'd25, 16'd2, 16'h4000, 16'h3333, 16'd2, 16'd25);
      pktType = PKT_QADV;
      setFields(16'd25, 16'd2, 16'h4000, 16'h3333, 16'd2, 16'd25);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chkAllZero("midReset");
      @(posedge clk); #1;
      sendPkt(PKT_HB, 16'd25, 16'd2, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 1'b0, 6);
      cmpHb("afterResetByte");

      repeat (3) @(posedge clk);
      #1;
      chk("modelDrained", 32'(expQ.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pkt_tx_builder.md
PKT_TX_BUILDER -- requirements
Module: pkt_tx_builder

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16, width of every packet field.
REQ-002 SHALL have parameter MEM_WIDTH, default 8, width of the outgoing byte stream.
REQ-003 clk  input  1  the single clock; all logic on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to build and send a packet.
REQ-006 pktType  input  8  packet code: 8'h01 heartbeat (HB), 8'h02 Q-advertisement (QADV); any other value is invalid.
REQ-007 myNodeID, myHops, myQValue, myEnergy, myHopsFromCH, myChosenCH  input  WORD_WIDTH each  this node's own fields, sampled at start.
REQ-008 txReady  input  1  downstream radio buffer accepts a byte this cycle.
REQ-009 txData  output  MEM_WIDTH  current outgoing byte.
REQ-010 txValid  output  1  txData is valid.
REQ-011 txLast  output  1  high with the final (checksum) byte.
REQ-012 busy  output  1  a packet is in progress.
REQ-013 done  output  1  one-cycle pulse after the last byte is accepted.
REQ-014 err  output  1  one-cycle pulse when start arrives with an invalid pktType.

Function
REQ-015 SHALL implement FSM states IDLE, SEND, CSUM, DONE.
REQ-016 In IDLE, start with a valid pktType SHALL latch pktType and all six fields into internal registers and enter SEND on the next edge.
REQ-017 In IDLE, start with an invalid pktType SHALL raise err for one cycle and stay in IDLE.
REQ-018 Byte order SHALL be: type byte, then fields MSB-first.
REQ-019 HB packets SHALL carry myNodeID and myHops.
REQ-020 QADV packets SHALL carry myNodeID, myHops, myQValue, myEnergy, myHopsFromCH and myChosenCH, in that order.
REQ-021 After the fields, a checksum byte SHALL be sent in state CSUM, equal to the XOR of all preceding bytes of the packet.
REQ-022 HB length SHALL be 6 bytes and QADV length 14 bytes, including the type and checksum bytes.
REQ-023 txValid SHALL be high in SEND and CSUM only, and SHALL first be high the cycle after start (latency 1).
REQ-024 A byte SHALL transfer only on a cycle where txValid and txReady are both high; the byte index and the running checksum SHALL advance only on a transfer.
REQ-025 While txValid is high and txReady is low, txData and txLast SHALL hold stable for any number of cycles.
REQ-026 A transfer of the last field byte SHALL move the FSM SEND->CSUM.
REQ-027 A transfer in CSUM SHALL move the FSM CSUM->DONE.
REQ-028 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-029 busy SHALL be high in SEND, CSUM and DONE.
REQ-030 start while busy SHALL be ignored, with no err and no change to latched fields.
REQ-031 Input field changes after the start cycle SHALL NOT affect the packet in flight.
REQ-032 The byte index SHALL be 4 bits, SHALL reset to 0 on each new packet, and SHALL never wrap within a packet.

Reset
REQ-033 On rst high at a clock edge, the FSM SHALL go to IDLE and txData, txValid, txLast, busy, done, err, the byte index, the checksum and all latched fields SHALL be 0.
REQ-034 rst mid-packet SHALL abort the packet with no done pulse; the next start SHALL begin a fresh packet at the type byte.
REQ-035 rst SHALL take priority over start in the same cycle.

Structure
REQ-036 A shared package pkt_pkg SHALL hold the type codes (PKT_HB=8'h01, PKT_QADV=8'h02), the lengths (HB_LEN=6, QADV_LEN=14) and the FSM state enum, so the receive side decodes against the same constants.
REQ-037 The block SHALL be a single module with no sub-modules; byte selection from the latched fields SHALL be a combinational mux indexed by the byte index.

Verification
REQ-038 HB: ID=25, hops=2, txReady tied high -> 01 00 19 00 02 1A on consecutive cycles starting 1 cycle after start; txLast on 1A; done on the next cycle.
REQ-039 QADV: ID=25, hops=2, Q=16'h4000, energy=16'h3333, hopsFromCH=2, chosenCH=25 -> 02 00 19 00 02 40 00 33 33 00 02 00 19 42.
REQ-040 Backpressure: same QADV with txReady low for 3 cycles at byte 5 -> byte 40 held stable throughout; sequence and checksum unchanged.
REQ-041 Invalid pktType=8'h07 -> err pulses once; txValid stays 0; busy stays 0.
REQ-042 start during a QADV packet, and field inputs changed mid-packet -> output bytes identical to REQ-039.
REQ-043 rst asserted after byte 4 -> all outputs 0 on the next cycle; a new HB start then yields REQ-038 exactly.
